// File: rtl/word_byte_seq_if.sv
// word_byte_seq_if -- bundles the CPU-side request port and the byte-bus port
// of word_byte_seq.
//   slave  : the sequencer's view. Takes CPU requests and byte-bus read
//            data/ready. Drives CPU results and byte-bus address/strobes.
//   master : the environment's view (CPU plus byte memory), the mirror image.
//   cpu_req/we/size/addr/wdata : access request (size 00 B, 01 H, 10/11 W)
//   cpu_rdata/ack/busy         : read result, completion pulse, in-progress flag
//   maddr/mwdata/mread/mwrite  : byte-bus address phase outputs
//   mrdata/mready              : byte-bus read data and ready (low = wait)
interface word_byte_seq_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [1:0]  cpu_size;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_busy;
   logic [15:0] maddr;
   logic [7:0]  mwdata;
   logic [7:0]  mrdata;
   logic        mread;
   logic        mwrite;
   logic        mready;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, mrdata, mready,
      output cpu_rdata, cpu_ack, cpu_busy, maddr, mwdata, mread, mwrite
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, mrdata, mready,
      input  cpu_rdata, cpu_ack, cpu_busy, maddr, mwdata, mread, mwrite
   );
endinterface

// File: rtl/word_byte_seq.sv
// word_byte_seq -- splits a byte/halfword/word CPU access into single-byte
// transfers on an 8-bit bus. Each byte uses an address phase (ADDR, strobe
// high) and a data phase (DATA, strobe low). Bytes go out at ascending,
// 16-bit-wrapping addresses. Data is little-endian.
//   Clk : clock, all state on the rising edge
//   Rst : synchronous active-high reset
//   bus : word_byte_seq_if.slave, CPU request port plus byte-bus port
module word_byte_seq (
   input  logic             Clk,
   input  logic             Rst,
   word_byte_seq_if.slave   bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]  state;
   logic        we_q;
   logic [1:0]  last_idx;   // N-1 for the latched size
   logic [15:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  idx;
   logic [1:0]  nidx;

   assign nidx         = idx + 2'd1;
   assign bus.cpu_busy = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         last_idx      <= 2'd0;
         addr_q        <= 16'd0;
         wdata_q       <= 32'd0;
         idx           <= 2'd0;
         bus.cpu_ack   <= 1'b0;
         bus.cpu_rdata <= 32'd0;
         bus.maddr     <= 16'd0;
         bus.mwdata    <= 8'd0;
         bus.mread     <= 1'b0;
         bus.mwrite    <= 1'b0;
      end else begin
         bus.cpu_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cpu_req) begin
                  we_q     <= bus.cpu_we;
                  addr_q   <= bus.cpu_addr;
                  wdata_q  <= bus.cpu_wdata;
                  idx      <= 2'd0;
                  // size 11 behaves as word
                  last_idx <= bus.cpu_size[1] ? 2'd3 : (bus.cpu_size[0] ? 2'd1 : 2'd0);
                  // address-phase outputs are registered so they are valid
                  // for the whole first ADDR cycle
                  bus.maddr  <= bus.cpu_addr;
                  bus.mwdata <= bus.cpu_wdata[7:0];
                  bus.mread  <= ~bus.cpu_we;
                  bus.mwrite <= bus.cpu_we;
                  if (!bus.cpu_we)
                     bus.cpu_rdata <= 32'd0;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (bus.mready) begin
                  // maddr/mwdata stay put: the bridge still needs them
                  bus.mread  <= 1'b0;
                  bus.mwrite <= 1'b0;
                  state      <= DATA;
               end
            end
            DATA: begin
               if (bus.mready) begin
                  if (!we_q)
                     bus.cpu_rdata[{idx, 3'b000} +: 8] <= bus.mrdata;
                  if (idx == last_idx) begin
                     bus.cpu_ack <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     idx        <= nidx;
                     bus.maddr  <= addr_q + {14'd0, nidx};
                     bus.mwdata <= wdata_q[{nidx, 3'b000} +: 8];
                     bus.mread  <= ~we_q;
                     bus.mwrite <= we_q;
                     state      <= ADDR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_word_byte_seq.sv
// tb_word_byte_seq -- directed self-checking bench for word_byte_seq.
// A byte memory answers reads combinationally from maddr. Each task drives
// one scenario and checks against hand-computed values. Cycle numbering
// counts the edge that accepts the request as the end of cycle 0.
module tb_word_byte_seq;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [7:0]  mem [0:65535];
   logic [15:0] la[$];    // bus addresses of completed address phases
   logic [7:0]  ld[$];    // mwdata of those phases
   logic        lw[$];    // 1 = write phase
   logic [15:0] lall[$];  // maddr sampled every cycle of the access

   word_byte_seq_if bus ();

   word_byte_seq dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   assign bus.mrdata = mem[bus.maddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one access. mready is low for cycles [stall_at, stall_at+stall_n).
   // lat is the cycle number in which cpu_ack was seen (60 = timeout).
   task automatic run_access(input logic we, input logic [1:0] size,
                             input logic [15:0] addr, input logic [31:0] wdata,
                             input int stall_at, input int stall_n,
                             output int lat);
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_size  = size;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.mready    = 1'b1;
      la.delete(); ld.delete(); lw.delete(); lall.delete();
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         bus.cpu_req = 1'b0;
         bus.mready  = !(lat >= stall_at && lat < stall_at + stall_n);
         lall.push_back(bus.maddr);
         if ((bus.mread || bus.mwrite) && bus.mready) begin
            la.push_back(bus.maddr);
            ld.push_back(bus.mwdata);
            lw.push_back(bus.mwrite);
            if (bus.mwrite) mem[bus.maddr] = bus.mwdata;
         end
      end while (!bus.cpu_ack && lat < 60);
      bus.mready = 1'b1;
   endtask

   task automatic test_reset;
      rst           = 1'b1;
      bus.cpu_req   = 1'b1;   // reset must win over a pending request
      bus.cpu_we    = 1'b0;
      bus.cpu_size  = 2'b10;
      bus.cpu_addr  = 16'h1234;
      bus.cpu_wdata = 32'h0;
      bus.mready    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.cpu_busy); end
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", bus.cpu_ack); end
      checks++; if ({bus.mread, bus.mwrite} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {bus.mread, bus.mwrite}); end
      checks++; if (bus.maddr !== 16'h0) begin errors++; $display("FAIL reset_maddr got %h exp 0000", bus.maddr); end
      checks++; if (bus.mwdata !== 8'h0) begin errors++; $display("FAIL reset_mwdata got %h exp 00", bus.mwdata); end
      checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.cpu_rdata); end
      bus.cpu_req = 1'b0;
      rst         = 1'b0;
   endtask

   task automatic test_word_read;
      int lat;
      logic [15:0] ea [4];
      ea = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
      run_access(1'b0, 2'b10, 16'h0100, 32'h0, 99, 0, lat);
      checks++; if (lat !== 9) begin errors++; $display("FAIL wr_latency got %0d exp 9", lat); end
      checks++;
      if (la.size() !== 4) begin errors++; $display("FAIL wr_nbytes got %0d exp 4", la.size()); end
      else for (int i = 0; i < 4; i++)
         if (la[i] !== ea[i] || lw[i] !== 1'b0) begin errors++; $display("FAIL wr_addr%0d got %h/%b exp %h/0", i, la[i], lw[i], ea[i]); end
      checks++; if (bus.cpu_rdata !== 32'h44332211) begin errors++; $display("FAIL wr_rdata got %h exp 44332211", bus.cpu_rdata); end
      checks++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_ack got %b exp 0", bus.cpu_busy); end
   endtask

   task automatic test_word_write;
      int lat;
      logic [15:0] ea [4];
      logic [7:0]  ed [4];
      ea = '{16'h0203, 16'h0204, 16'h0205, 16'h0206};
      ed = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      run_access(1'b1, 2'b10, 16'h0203, 32'hA1B2C3D4, 99, 0, lat);
      checks++; if (lat !== 9) begin errors++; $display("FAIL ww_latency got %0d exp 9", lat); end
      checks++;
      if (la.size() !== 4) begin errors++; $display("FAIL ww_nbytes got %0d exp 4", la.size()); end
      else for (int i = 0; i < 4; i++)
         if (la[i] !== ea[i] || ld[i] !== ed[i] || lw[i] !== 1'b1) begin
            errors++; $display("FAIL ww_byte%0d got %h/%h/%b exp %h/%h/1", i, la[i], ld[i], lw[i], ea[i], ed[i]);
         end
      checks++; if (bus.cpu_rdata !== 32'h44332211) begin errors++; $display("FAIL ww_rdata_kept got %h exp 44332211", bus.cpu_rdata); end
      @(negedge clk);
      checks++; if (bus.maddr !== 16'h0206 || bus.mwrite !== 1'b0 || bus.mread !== 1'b0) begin
         errors++; $display("FAIL ww_idle_hold got %h/%b%b exp 0206/00", bus.maddr, bus.mread, bus.mwrite); end
   endtask

   task automatic test_half_wrap;
      int lat;
      run_access(1'b0, 2'b01, 16'hFFFF, 32'h0, 99, 0, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL hw_latency got %0d exp 5", lat); end
      checks++;
      if (la.size() !== 2) begin errors++; $display("FAIL hw_nbytes got %0d exp 2", la.size()); end
      else if (la[0] !== 16'hFFFF || la[1] !== 16'h0000) begin errors++; $display("FAIL hw_wrap got %h,%h exp ffff,0000", la[0], la[1]); end
      checks++; if (bus.cpu_rdata !== 32'h00007E5A) begin errors++; $display("FAIL hw_rdata got %h exp 00007e5a", bus.cpu_rdata); end
   endtask

   task automatic test_wait_states;
      int lat;
      run_access(1'b0, 2'b00, 16'h0010, 32'h0, 2, 3, lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL ws_latency got %0d exp 6", lat); end
      checks++;
      if (lall.size() < 5) begin errors++; $display("FAIL ws_trace got %0d cycles exp 6", lall.size()); end
      else for (int i = 0; i < 5; i++)
         if (lall[i] !== 16'h0010) begin errors++; $display("FAIL ws_hold cycle %0d got %h exp 0010", i + 1, lall[i]); end
      checks++; if (bus.cpu_rdata !== 32'h0000009C) begin errors++; $display("FAIL ws_rdata got %h exp 0000009c", bus.cpu_rdata); end
   endtask

   task automatic test_reset_abort;
      int lat;
      bit saw_ack;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b10;
      bus.cpu_addr = 16'h0500; bus.cpu_wdata = 32'hA1B2C3D4; bus.mready = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.cpu_req = 1'b0;
      end
      checks++; if (bus.maddr !== 16'h0502 || bus.mwrite !== 1'b1) begin
         errors++; $display("FAIL ra_third_byte got %h/%b exp 0502/1", bus.maddr, bus.mwrite); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.cpu_busy !== 1'b0 || bus.cpu_ack !== 1'b0) begin
         errors++; $display("FAIL ra_idle got busy %b ack %b exp 0 0", bus.cpu_busy, bus.cpu_ack); end
      checks++; if (bus.maddr !== 16'h0 || bus.mwdata !== 8'h0 || bus.mwrite !== 1'b0 || bus.mread !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
         errors++; $display("FAIL ra_outputs got %h/%h/%b%b/%h exp 0000/00/00/0", bus.maddr, bus.mwdata, bus.mread, bus.mwrite, bus.cpu_rdata); end
      saw_ack = 1'b0;
      repeat (4) begin @(negedge clk); if (bus.cpu_ack) saw_ack = 1'b1; end
      checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL ra_no_ack got ack exp none"); end
      run_access(1'b0, 2'b00, 16'h0010, 32'h0, 99, 0, lat);
      checks++; if (lat !== 3 || bus.cpu_rdata !== 32'h0000009C) begin
         errors++; $display("FAIL ra_recover got %0d/%h exp 3/0000009c", lat, bus.cpu_rdata); end
   endtask

   task automatic test_back_to_back;
      int c;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b00;
      bus.cpu_addr = 16'h0400; bus.cpu_wdata = 32'h000000EE; bus.mready = 1'b1;
      @(posedge clk);
      @(negedge clk);   // cycle 1: request stays high with the second access's fields
      bus.cpu_we = 1'b0; bus.cpu_size = 2'b01; bus.cpu_addr = 16'h0300; bus.cpu_wdata = 32'h0;
      checks++; if (bus.maddr !== 16'h0400 || bus.mwdata !== 8'hEE || bus.mwrite !== 1'b1 || bus.cpu_busy !== 1'b1) begin
         errors++; $display("FAIL bb_first got %h/%h/%b/%b exp 0400/ee/1/1", bus.maddr, bus.mwdata, bus.mwrite, bus.cpu_busy); end
      @(negedge clk);   // cycle 2
      @(negedge clk);   // cycle 3: first ack
      checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_busy !== 1'b0) begin
         errors++; $display("FAIL bb_ack1 got ack %b busy %b exp 1 0", bus.cpu_ack, bus.cpu_busy); end
      @(negedge clk);   // cycle 4: second request accepted at end of cycle 3
      bus.cpu_req = 1'b0;
      checks++; if (bus.cpu_busy !== 1'b1 || bus.maddr !== 16'h0300 || bus.mread !== 1'b1) begin
         errors++; $display("FAIL bb_accept2 got busy %b %h rd %b exp 1 0300 1", bus.cpu_busy, bus.maddr, bus.mread); end
      c = 4;
      while (!bus.cpu_ack && c < 60) begin @(negedge clk); c++; end
      checks++; if (c !== 8) begin errors++; $display("FAIL bb_ack2_cycle got %0d exp 8", c); end
      checks++; if (bus.cpu_rdata !== 32'h00003412) begin errors++; $display("FAIL bb_rdata got %h exp 00003412", bus.cpu_rdata); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
      mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
      mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'h7E;
      mem[16'h0010] = 8'h9C;
      mem[16'h0300] = 8'h12; mem[16'h0301] = 8'h34;
      test_reset();
      test_word_read();
      test_word_write();
      test_half_wrap();
      test_wait_states();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/word_byte_seq.md
WORD_BYTE_SEQ -- requirements
Module: word_byte_seq

Interface
REQ-001 SHALL provide ports: Clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: Rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: cpu_req  in  1  CPU access request, sampled only in IDLE.
REQ-004 SHALL provide: cpu_we  in  1  1 = write, 0 = read.
REQ-005 SHALL provide: cpu_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as 10.
REQ-006 SHALL provide: cpu_addr  in  16  byte address of lowest byte.
REQ-007 SHALL provide: cpu_wdata  in  32  write data, little-endian.
REQ-008 SHALL provide: cpu_rdata  out  32  read data, little-endian.
REQ-009 SHALL provide: cpu_ack  out  1  one-cycle completion pulse.
REQ-010 SHALL provide: cpu_busy  out  1  access in progress.
REQ-011 SHALL provide: maddr  out  16  byte-bus address.
REQ-012 SHALL provide: mwdata  out  8  byte-bus write data.
REQ-013 SHALL provide: mrdata  in  8  byte-bus read data, valid in data phase.
REQ-014 SHALL provide: mread, mwrite  out  1 each  byte-bus address-phase strobes.
REQ-015 SHALL provide: mready  in  1  byte-bus ready; low = wait state.

Function
REQ-016 SHALL implement states IDLE, ADDR, DATA.
REQ-017 In IDLE with cpu_req=1, SHALL latch cpu_we, cpu_size, cpu_addr, cpu_wdata, clear byte index to 0, set N = 1/2/4 per size, and go to ADDR.
REQ-018 cpu_req SHALL be ignored outside IDLE; latched request fields SHALL NOT change until the next acceptance.
REQ-019 In ADDR, SHALL drive maddr = latched addr + index (mod 2^16, wraps FFFF->0000), mread = !we, mwrite = we, mwdata = latched wdata byte[index].
REQ-020 In ADDR, SHALL go to DATA on an edge where mready=1; if mready=0, SHALL remain in ADDR with all outputs unchanged.
REQ-021 In DATA, SHALL drive mread=mwrite=0 and hold maddr and mwdata at their ADDR values, because the downstream bridge selects the read byte from maddr[0] and registers write data.
REQ-022 In DATA with mready=1 on a read, SHALL write mrdata into cpu_rdata byte[index].
REQ-023 In DATA with mready=1, if index < N-1, SHALL increment index and return to ADDR.
REQ-024 In DATA with mready=1, if index = N-1, SHALL go to IDLE and assert cpu_ack for exactly the next cycle.
REQ-025 In DATA with mready=0, SHALL hold state, index and outputs.
REQ-026 On read acceptance, SHALL clear cpu_rdata to 0, so unused upper bytes read 0 (no sign extension).
REQ-027 cpu_rdata SHALL hold its value from the ack cycle until the next read acceptance; writes SHALL leave cpu_rdata unchanged.
REQ-028 Misaligned halfword/word accesses SHALL be legal and sequenced bytewise at ascending addresses.
REQ-029 cpu_busy SHALL be 1 in ADDR and DATA and 0 in IDLE, including the ack cycle.
REQ-030 A new cpu_req SHALL be acceptable in the ack cycle.
REQ-031 Zero-wait latency: req sampled at cycle 0; ack in cycle 1+2N (byte 3, halfword 5, word 9); each mready=0 cycle adds one.
REQ-032 In IDLE, SHALL drive mread=mwrite=0 and hold maddr/mwdata at their last values.

Reset
REQ-033 On Rst=1 at a clock edge, SHALL enter IDLE with index=0, cpu_ack=0, cpu_busy=0, mread=mwrite=0, maddr=0, mwdata=0, cpu_rdata=0.
REQ-034 Rst mid-access SHALL abort without ack; the partial bytes already written are not undone.
REQ-035 Rst SHALL take priority over cpu_req on the same edge.

Verification
REQ-036 Word read, addr 0x0100, mready=1, memory 0x0100..0x0103 = 11,22,33,44 -> maddr 0100..0103 in order; cpu_rdata=0x44332211; ack in cycle 9.
REQ-037 Word write 0xA1B2C3D4 to 0x0203 -> mwrite pulses with maddr/mwdata 0203/D4, 0204/C3, 0205/B2, 0206/A1; ack in cycle 9; cpu_rdata unchanged.
REQ-038 Halfword read at 0xFFFF with bytes FF->0x5A, 0000->0x7E -> maddr FFFF then 0000; cpu_rdata=0x00007E5A.
REQ-039 Byte read at 0x0010 with mready=0 for 3 cycles in DATA -> maddr held 0010; ack in cycle 6; cpu_rdata=0x000000xx.
REQ-040 Rst=1 during the third byte of a word write -> next cycle IDLE, all outputs at reset values, no ack; then a byte read completes normally.
REQ-041 Back-to-back: second cpu_req held high through the first ack -> accepted in the ack cycle; second ack 2N+1 cycles later; cpu_req asserted while busy is ignored.
